// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full adder, one bit pair per clock, LSB first.
// Define SERIAL_SUB_EN to add the sub port (a - b via inverted B and a carry-in of 1).

module serial_adder_fa (
  input  logic a,
  input  logic b,
  input  logic cy_in,
  output logic sum,
  output logic cy_out
);
  assign sum    = a ^ b ^ cy_in;
  assign cy_out = (a & b) | (cy_in & (a ^ b));
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_SUB_EN
  input  logic             sub,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] shA_q, shB_q, res_q, res_d, sum_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q, busy_q, done_q, cout_q;
  logic             faB, faSum, faCy, subSel, carryInit;

`ifdef SERIAL_SUB_EN
  logic sub_q;
  assign subSel    = sub_q;
  assign carryInit = sub | cin;
`else
  assign subSel    = 1'b0;
  assign carryInit = cin;
`endif

  // Subtraction reuses the adder: invert each B bit and start with carry 1.
  assign faB = shB_q[0] ^ subSel;

  serial_adder_fa u_fa (
    .a      (shA_q[0]),
    .b      (faB),
    .cy_in  (carry_q),
    .sum    (faSum),
    .cy_out (faCy)
  );

  assign res_d = (res_q >> 1) | {faSum, {(WIDTH-1){1'b0}}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      shA_q   <= '0;
      shB_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
`ifdef SERIAL_SUB_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            shA_q   <= a;
            shB_q   <= b;
            carry_q <= carryInit;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
`ifdef SERIAL_SUB_EN
            sub_q   <= sub;
`endif
          end
        end
        RUN: begin
          shA_q   <= shA_q >> 1;
          shB_q   <= shB_q >> 1;
          carry_q <= faCy;
          res_q   <= res_d;
          cnt_q   <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(WIDTH-1)) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            sum_q   <= res_d;
            cout_q  <= faCy;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl: directed cases plus random operands against
// an arithmetic reference model. Define SERIAL_SUB_EN to also exercise subtraction.
module tb_serial_adder_ctrl;
  localparam int WIDTH = 8;
`ifdef SERIAL_SUB_EN
  localparam bit SUB_EN = 1'b1;
`else
  localparam bit SUB_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [WIDTH-1:0] a, b;
  logic             cin;
`ifdef SERIAL_SUB_EN
  logic             sub;
`endif
  logic             busy, done, cout;
  logic [WIDTH-1:0] sum;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
`ifdef SERIAL_SUB_EN
    .sub   (sub),
`endif
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, {cout, sum}.
  function automatic logic [WIDTH:0] refResult(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                               input logic c, input logic s);
    int unsigned      total;
    logic [WIDTH-1:0] diff;
    if (s) begin
      diff = x - y;
      return {(x >= y), diff};
    end
    total = x + y + c;
    return total[WIDTH:0];
  endfunction

  task automatic applyStimulus(input string tag, input logic [WIDTH-1:0] aIn, input logic [WIDTH-1:0] bIn,
                               input logic cinIn, input logic subIn, output logic [WIDTH:0] expv);
    int lat, busyCnt;
    expv = refResult(aIn, bIn, cinIn, subIn);
    @(negedge clk);
    a = aIn; b = bIn; cin = cinIn; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = subIn;
`endif
    @(posedge clk);
    #1;
    start = 1'b0;
    a = WIDTH'($urandom); b = WIDTH'($urandom); cin = 1'($urandom);
`ifdef SERIAL_SUB_EN
    sub = 1'($urandom);
`endif
    lat = 0; busyCnt = 0;
    @(negedge clk);
    while (!done && lat < WIDTH + 4) begin
      if (busy) busyCnt++;
      @(negedge clk);
      lat++;
    end
    checkOutput({tag, ".done"}, done, 1);
    checkOutput({tag, ".latency"}, lat, WIDTH);
    checkOutput({tag, ".busyCycles"}, busyCnt, WIDTH);
    checkOutput({tag, ".sum"}, sum, expv[WIDTH-1:0]);
    checkOutput({tag, ".cout"}, cout, expv[WIDTH]);
    @(negedge clk);
    checkOutput({tag, ".pulseEnd"}, done, 0);
    checkOutput({tag, ".idleBusy"}, busy, 0);
    checkOutput({tag, ".sumHold"}, sum, expv[WIDTH-1:0]);
  endtask

  initial begin
    logic [WIDTH:0]   expv;
    logic [WIDTH:0]   expQ[$];
    logic [WIDTH-1:0] heldSum;
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rs;
    int               doneCnt, cyc, lastCyc, pulses;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    #1;
    checkOutput("reset.busy", busy, 0);
    checkOutput("reset.done", done, 0);
    checkOutput("reset.sum", sum, 0);
    checkOutput("reset.cout", cout, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    applyStimulus("t1", 8'h5A, 8'h3C, 1'b0, 1'b0, expv);
    checkOutput("t1.specSum", sum, 8'h96);
    applyStimulus("t2a", 8'hFF, 8'h01, 1'b0, 1'b0, expv);
    checkOutput("t2a.specCout", cout, 1);
    applyStimulus("t2b", 8'hFF, 8'h00, 1'b1, 1'b0, expv);
    checkOutput("t2b.specSum", sum, 8'h00);

    // Second start during RUN must be ignored.
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    repeat (3) @(negedge clk);
    a = 8'hF0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    doneCnt = 0;
    repeat (2 * WIDTH + 4) begin
      @(negedge clk);
      if (done) begin
        doneCnt++;
        checkOutput("t3.sum", sum, 8'h02);
      end
    end
    checkOutput("t3.doneCount", doneCnt, 1);

    // Asynchronous reset in the middle of RUN.
    @(negedge clk);
    a = 8'h77; b = 8'h11; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("t4.busy", busy, 0);
    checkOutput("t4.done", done, 0);
    checkOutput("t4.sum", sum, 0);
    checkOutput("t4.cout", cout, 0);
    @(negedge clk);
    rst_n = 1'b1;
    doneCnt = 0;
    repeat (WIDTH + 2) begin
      @(negedge clk);
      if (done) doneCnt++;
    end
    checkOutput("t4.noDone", doneCnt, 0);
    applyStimulus("t4b", 8'h10, 8'h20, 1'b0, 1'b0, expv);
    checkOutput("t4b.specSum", sum, 8'h30);

    // Start held high: back-to-back operations, new operands loaded after each pulse.
    heldSum = 8'h30;
    @(negedge clk);
    ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
    a = ra; b = rb; cin = rc; start = 1'b1;
`ifdef SERIAL_SUB_EN
    sub = 1'b0;
`endif
    expQ.push_back(refResult(ra, rb, rc, 1'b0));
    cyc = 0; lastCyc = 0; pulses = 0;
    while (pulses < 3 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (done) begin
        expv = expQ.pop_front();
        checkOutput("t5.sum", sum, expv[WIDTH-1:0]);
        checkOutput("t5.cout", cout, expv[WIDTH]);
        if (pulses > 0) checkOutput("t5.gap", cyc - lastCyc, WIDTH + 2);
        lastCyc = cyc;
        pulses++;
        heldSum = expv[WIDTH-1:0];
        if (pulses < 3) begin
          ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
          a = ra; b = rb; cin = rc;
          expQ.push_back(refResult(ra, rb, rc, 1'b0));
        end else begin
          start = 1'b0;
        end
      end else begin
        checkOutput("t5.hold", sum, heldSum);
      end
    end
    checkOutput("t5.pulses", pulses, 3);
    start = 1'b0;
    repeat (3) @(negedge clk);

`ifdef SERIAL_SUB_EN
    applyStimulus("t6a", 8'h0A, 8'h03, 1'b0, 1'b1, expv);
    checkOutput("t6a.specSum", sum, 8'h07);
    checkOutput("t6a.specCout", cout, 1);
    applyStimulus("t6b", 8'h03, 8'h0A, 1'b1, 1'b1, expv);
    checkOutput("t6b.specSum", sum, 8'hF9);
    checkOutput("t6b.specCout", cout, 0);
`endif

    for (int i = 0; i < 16; i++) begin
      ra = WIDTH'($urandom); rb = WIDTH'($urandom); rc = 1'($urandom);
      rs = SUB_EN ? 1'($urandom) : 1'b0;
      applyStimulus("rand", ra, rb, rc, rs, expv);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
